// File: rtl/snn_pkg.sv
// Shared SNN definitions for the spike event logger.
// Holds the default frame timing, record field widths and the logger
// run-state enum, so the logger and anything that decodes its records
// agree on the layout.
package snn_pkg;

    // 100 MHz clock, 100 kHz spike frame rate.
    localparam int CLK_PER_FRAME_DEF = 1000;
    localparam int FRAME_W_DEF       = 10;
    localparam int CNT_W_DEF         = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } log_state_e;

endpackage

// File: rtl/spike_evt_fifo.sv
// Synchronous FIFO for spike event records.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   push, push_data       - write request and record
//   pop                   - read request (ignored when empty)
//   pop_data              - head record, reads 0 when empty
//   full, empty           - occupancy flags
// A push while full is accepted only if a pop happens in the same cycle;
// the freed slot is the one being written.
module spike_evt_fifo #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]       wr_ptr, rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: pop_data is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/spike_event_logger.sv
// Spike event logger.
// Counts rising edges of the SNN output spike in fixed-length frames and
// queues one {frame_idx, spike_count} record per frame that saw spikes.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   i_enable        - level, high = logging runs
//   i_output_spike  - SNN output spike, synchronous to clk
//   o_evt_valid     - record available
//   i_evt_ready     - consumer accepts record
//   o_evt_data      - {frame_idx, spike_count}
//   o_total_spikes  - saturating spike edge count since enable
//   o_overflow      - sticky, a record was dropped on a full FIFO
module spike_event_logger
    import snn_pkg::*;
#(
    parameter int CLK_PER_FRAME = CLK_PER_FRAME_DEF,
    parameter int FRAME_W       = FRAME_W_DEF,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_enable,
    input  logic                     i_output_spike,
    output logic                     o_evt_valid,
    input  logic                     i_evt_ready,
    output logic [FRAME_W+CNT_W-1:0] o_evt_data,
    output logic [15:0]              o_total_spikes,
    output logic                     o_overflow
);

    localparam int CYC_W = (CLK_PER_FRAME > 1) ? $clog2(CLK_PER_FRAME) : 1;
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(CLK_PER_FRAME - 1);

    log_state_e         state, state_nxt;
    logic [CYC_W-1:0]   cyc;
    logic [FRAME_W-1:0] frame_idx;
    logic [CNT_W-1:0]   frame_cnt, cnt_inc;
    logic               spike_q;
    logic               edge_det, last_cyc, running, start;
    logic               push_req, pop_fire, fifo_full, fifo_empty;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        running   = 1'b0;
        case (state)
            ST_IDLE: if (i_enable) begin
                state_nxt = ST_RUN;
                start     = 1'b1;
            end
            ST_RUN: begin
                if (!i_enable) state_nxt = ST_IDLE;
                else           running   = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- frame counting ----------------
    assign edge_det = i_output_spike && !spike_q;
    assign last_cyc = (cyc == LAST_CYC);
    // Includes this cycle's edge so a last-cycle edge lands in the closing frame.
    assign cnt_inc  = (edge_det && frame_cnt != '1) ? frame_cnt + 1'b1 : frame_cnt;
    assign push_req = running && last_cyc && (cnt_inc != '0);
    assign pop_fire = o_evt_valid && i_evt_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            spike_q        <= 1'b0;
            cyc            <= '0;
            frame_idx      <= '0;
            frame_cnt      <= '0;
            o_total_spikes <= '0;
            o_overflow     <= 1'b0;
        end else begin
            spike_q <= i_output_spike;
            if (start) begin
                cyc            <= '0;
                frame_idx      <= '0;
                frame_cnt      <= '0;
                o_total_spikes <= '0;
                o_overflow     <= 1'b0;
            end else if (running) begin
                if (edge_det && o_total_spikes != 16'hFFFF)
                    o_total_spikes <= o_total_spikes + 16'd1;
                if (last_cyc) begin
                    cyc       <= '0;
                    frame_cnt <= '0;
                    frame_idx <= frame_idx + 1'b1;
                end else begin
                    cyc       <= cyc + 1'b1;
                    frame_cnt <= cnt_inc;
                end
                if (push_req && fifo_full && !pop_fire)
                    o_overflow <= 1'b1;
            end
        end
    end

    // ---------------- record buffer ----------------
    spike_evt_fifo #(
        .DATA_W (FRAME_W + CNT_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data ({frame_idx, cnt_inc}),
        .pop       (i_evt_ready),
        .pop_data  (o_evt_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign o_evt_valid = !fifo_empty;

endmodule

// File: tb/tb_spike_event_logger.sv
module tb_spike_event_logger;

    localparam int CPF = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_output_spike = 1'b0;
    logic        i_evt_ready = 1'b1;
    logic        o_evt_valid;
    logic [13:0] o_evt_data;
    logic [15:0] o_total_spikes;
    logic        o_overflow;

    int checks = 0;
    int errors = 0;
    logic [13:0] sb[$];

    spike_event_logger dut (
        .clk            (clk),
        .rst            (rst),
        .i_enable       (i_enable),
        .i_output_spike (i_output_spike),
        .o_evt_valid    (o_evt_valid),
        .i_evt_ready    (i_evt_ready),
        .o_evt_data     (o_evt_data),
        .o_total_spikes (o_total_spikes),
        .o_overflow     (o_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] rec(input int f, input int n);
        logic [9:0] fi;
        logic [3:0] ni;
        fi = f[9:0];
        ni = n[3:0];
        return {fi, ni};
    endfunction

    // Scoreboard: every accepted record must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && o_evt_valid && i_evt_ready) begin
            logic [13:0] exp_r;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_record got=%h expected=none", o_evt_data);
            end else begin
                exp_r = sb.pop_front();
                if (o_evt_data !== exp_r) begin
                    errors++;
                    $display("FAIL record got=%h expected=%h", o_evt_data, exp_r);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; i_enable = 1'b0; i_output_spike = 1'b0; i_evt_ready = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    task automatic start_run;
        i_enable = 1'b1; i_output_spike = 1'b0;
        tick;
    endtask

    task automatic stop_run;
        i_enable = 1'b0; i_output_spike = 1'b0;
        repeat (3) tick;
    endtask

    // nedge one-cycle pulses at cycles 10,12,14,...
    task automatic run_frame(input int nedge);
        for (int c = 0; c < CPF; c++) begin
            i_output_spike = (c >= 10) && (c < 10 + 2 * nedge) && (c % 2 == 0);
            tick;
        end
        i_output_spike = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; i_enable = 1'b1; i_output_spike = 1'b1;
        tick;
        checks++;
        if (o_evt_valid !== 1'b0 || o_evt_data !== 14'd0 || o_total_spikes !== 16'd0 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got=%b/%h/%h/%b expected=0/0/0/0",
                     o_evt_valid, o_evt_data, o_total_spikes, o_overflow);
        end
        rst = 1'b0; i_enable = 1'b0; i_output_spike = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        do_reset;
        start_run;
        for (int c = 0; c < CPF; c++) begin
            i_output_spike = (c == 10) || (c == 20) || (c == 30);
            if (c == CPF - 1) begin
                checks++;
                if (o_evt_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_early_valid got=%b expected=0", o_evt_valid);
                end
            end
            tick;
        end
        sb.push_back(rec(0, 3));
        checks++;
        if (o_evt_valid !== 1'b1 || o_evt_data !== rec(0, 3)) begin
            errors++;
            $display("FAIL basic_latency got=%b/%h expected=1/%h", o_evt_valid, o_evt_data, rec(0, 3));
        end
        checks++;
        if (o_total_spikes !== 16'd3) begin
            errors++;
            $display("FAIL basic_total got=%0d expected=3", o_total_spikes);
        end
        stop_run;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL basic_drain got=%0d expected=0 pending", sb.size());
        end
    endtask

    task automatic test_held;
        do_reset;
        start_run;
        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < CPF; c++) begin
                i_output_spike = (f == 2) && (c >= 100) && (c < 600);
                tick;
            end
            if (f == 2) sb.push_back(rec(2, 1));
        end
        checks++;
        if (o_total_spikes !== 16'd1) begin
            errors++;
            $display("FAIL held_total got=%0d expected=1", o_total_spikes);
        end
        stop_run;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL held_drain got=%0d expected=0 pending", sb.size());
        end
    endtask

    task automatic test_saturate;
        do_reset;
        start_run;
        run_frame(20);
        sb.push_back(rec(0, 15));
        checks++;
        if (o_evt_data !== rec(0, 15)) begin
            errors++;
            $display("FAIL sat_count got=%h expected=%h", o_evt_data, rec(0, 15));
        end
        checks++;
        if (o_total_spikes !== 16'd20) begin
            errors++;
            $display("FAIL sat_total got=%0d expected=20", o_total_spikes);
        end
        stop_run;
    endtask

    task automatic test_overflow;
        do_reset;
        i_evt_ready = 1'b0;
        start_run;
        for (int f = 0; f < 17; f++) begin
            run_frame(f % 3 + 1);
            if (f < 16) sb.push_back(rec(f, f % 3 + 1));
            if (f == 15) begin
                checks++;
                if (o_overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_early got=%b expected=0", o_overflow);
                end
            end
        end
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag got=%b expected=1", o_overflow);
        end
        checks++;
        if (o_evt_valid !== 1'b1 || o_evt_data !== rec(0, 1)) begin
            errors++;
            $display("FAIL ovf_head_stable got=%b/%h expected=1/%h", o_evt_valid, o_evt_data, rec(0, 1));
        end
        // Drain while idle.
        i_enable = 1'b0;
        tick;
        i_evt_ready = 1'b1;
        for (int k = 0; k < 64 && sb.size() != 0; k++) tick;
        tick;
        checks++;
        if (sb.size() != 0 || o_evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drain got=%0d pending valid=%b expected=0 pending valid=0", sb.size(), o_evt_valid);
        end
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got=%b expected=1", o_overflow);
        end
    endtask

    task automatic test_frame_boundary;
        // Edge on the last cycle of frame 4, held over the wrap.
        do_reset;
        start_run;
        for (int f = 0; f < 6; f++) begin
            for (int c = 0; c < CPF; c++) begin
                i_output_spike = (f == 4 && (c == 200 || c == CPF - 1)) ||
                                 (f == 5 && (c == 0 || c == 500));
                tick;
            end
            if (f == 4) sb.push_back(rec(4, 2));
            if (f == 5) sb.push_back(rec(5, 1));
        end
        checks++;
        if (o_total_spikes !== 16'd3) begin
            errors++;
            $display("FAIL bound_total got=%0d expected=3", o_total_spikes);
        end
        stop_run;
        // Fresh edge on the first cycle of frame 5.
        do_reset;
        start_run;
        for (int f = 0; f < 6; f++) begin
            for (int c = 0; c < CPF; c++) begin
                i_output_spike = (f == 4 && c == 10) || (f == 5 && c == 0);
                tick;
            end
            if (f == 4) sb.push_back(rec(4, 1));
            if (f == 5) sb.push_back(rec(5, 1));
        end
        stop_run;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL bound_drain got=%0d expected=0 pending", sb.size());
        end
    endtask

    task automatic test_abort_and_reset;
        do_reset;
        start_run;
        for (int c = 0; c < 400; c++) begin
            i_output_spike = (c == 10) || (c == 20);
            tick;
        end
        i_enable = 1'b0; i_output_spike = 1'b0;
        repeat (1100) tick;
        checks++;
        if (o_evt_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL abort_no_record got=%b expected=0", o_evt_valid);
        end
        checks++;
        if (o_total_spikes !== 16'd2) begin
            errors++;
            $display("FAIL abort_total got=%0d expected=2", o_total_spikes);
        end
        // Park a record, run into the next frame, then reset during a handshake.
        i_evt_ready = 1'b0;
        start_run;
        run_frame(1);
        checks++;
        if (o_evt_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup got=%b expected=1", o_evt_valid);
        end
        for (int c = 0; c < 300; c++) begin
            i_output_spike = (c == 50);
            tick;
        end
        rst = 1'b1; i_evt_ready = 1'b1; i_output_spike = 1'b1;
        tick;
        checks++;
        if (o_evt_valid !== 1'b0 || o_evt_data !== 14'd0 || o_total_spikes !== 16'd0 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_frame got=%b/%h/%h/%b expected=0/0/0/0",
                     o_evt_valid, o_evt_data, o_total_spikes, o_overflow);
        end
        rst = 1'b0; i_enable = 1'b0; i_output_spike = 1'b0;
        repeat (3) tick;
        checks++;
        if (o_evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_fifo_empty got=%b expected=0", o_evt_valid);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_held;
        test_saturate;
        test_overflow;
        test_frame_boundary;
        test_abort_and_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
